// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C power-up init sequencer.
// Holds the FSM state encoding, the bus field widths and a constant helper.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE,
        GAP,
        DONE,
        ERR
    } state_t;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam logic RW_WRITE = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Fixed power-up register table: index -> {slave addr[6:0], data[7:0]}.
// Indices at or beyond N_ENTRIES read as zero.
module i2c_init_rom
    import i2c_pkg::*;
#(
    parameter int N_ENTRIES = 4,
    parameter int IDX_W     = 4
) (
    input  logic [IDX_W-1:0]                 index,
    output logic [I2C_ADDR_W+I2C_DATA_W-1:0] entry
);

    always_comb begin
        entry = '0;
        if (int'(index) < N_ENTRIES) begin
            case (int'(index))
                0:       entry = {7'h3B, 8'h01};
                1:       entry = {7'h3B, 8'h80};
                2:       entry = {7'h3B, 8'h45};
                3:       entry = {7'h3B, 8'hA5};
                4:       entry = {7'h3B, 8'h10};
                5:       entry = {7'h3B, 8'h20};
                6:       entry = {7'h3B, 8'h30};
                7:       entry = {7'h3B, 8'h40};
                default: entry = '0;
            endcase
        end
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init ROM, issuing one I2C write per entry with a fixed idle gap.
// Handshake: m_send stays high until m_busy is seen high; m_busy low again ends the transfer.
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter int N_ENTRIES   = 4,
    parameter int GAP_CYCLES  = 500,
    parameter int ACK_TIMEOUT = 1000,
    parameter int IDX_W       = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  m_busy,
    output logic                  m_send,
    output logic                  m_rw,
    output logic [I2C_ADDR_W-1:0] m_addr,
    output logic [I2C_DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]      step,
    output logic                  active,
    output logic                  done,
    output logic                  err,
    output state_t                dbg_state
);

    localparam int CNT_W = $clog2(max2(GAP_CYCLES, ACK_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] STEP_LAST = IDX_W'(N_ENTRIES - 1);

    state_t                                state, state_n;
    logic [CNT_W-1:0]                      cnt, cnt_n;
    logic [IDX_W-1:0]                      step_n;
    logic                                  start_q, start_rise;
    logic                                  load_en;
    logic [I2C_ADDR_W+I2C_DATA_W-1:0]      rom_entry;

    i2c_init_rom #(
        .N_ENTRIES(N_ENTRIES),
        .IDX_W    (IDX_W)
    ) u_rom (
        .index(step),
        .entry(rom_entry)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            step       <= '0;
            m_addr     <= '0;
            m_data     <= '0;
            start_q    <= 1'b0;
            start_rise <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            step       <= step_n;
            start_q    <= start;
            // Registered edge pulse keeps start-to-send latency at three cycles.
            start_rise <= start & ~start_q;
            if (load_en) begin
                {m_addr, m_data} <= rom_entry;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        step_n  = step;
        load_en = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_rise) begin
                    state_n = LOAD;
                    step_n  = '0;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                cnt_n   = '0;
                state_n = SEND;
            end
            SEND: begin
                if (m_busy) begin
                    state_n = WAIT_DONE;
                    cnt_n   = '0;
                end else if (cnt == ACK_LAST) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!m_busy) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (step == STEP_LAST) begin
                        state_n = DONE;
                    end else begin
                        step_n  = step + 1'b1;
                        state_n = LOAD;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign m_send    = (state == SEND);
    assign m_rw      = RW_WRITE;
    assign active    = (state == LOAD) || (state == SEND) ||
                       (state == WAIT_DONE) || (state == GAP);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign dbg_state = state;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a simple I2C_master busy model.
// Expected bytes come from a hand-written table; sends are scoreboarded in order.
module tb_i2c_init_sequencer;
    import i2c_pkg::*;

    localparam int N_ENTRIES   = 4;
    localparam int GAP_CYCLES  = 5;
    localparam int ACK_TIMEOUT = 10;
    localparam int IDX_W       = 4;

    // ---------------- clock / reset ----------------
    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_send, m_rw, active, done, err;
    logic [6:0]       m_addr;
    logic [7:0]       m_data;
    logic [IDX_W-1:0] step;
    state_t           dbg_state;

    i2c_init_sequencer #(
        .N_ENTRIES  (N_ENTRIES),
        .GAP_CYCLES (GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .IDX_W      (IDX_W)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .m_busy   (m_busy),
        .m_send   (m_send),
        .m_rw     (m_rw),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .step     (step),
        .active   (active),
        .done     (done),
        .err      (err),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-written init table: {addr, data}
    logic [14:0] exp_tab [N_ENTRIES] = '{
        {7'b0111011, 8'h01}, {7'b0111011, 8'h80},
        {7'b0111011, 8'h45}, {7'b0111011, 8'hA5}
    };
    logic [14:0] exp_q[$];

    task automatic push_run();
        for (int i = 0; i < N_ENTRIES; i++) exp_q.push_back(exp_tab[i]);
    endtask

    // ---------------- busy model ----------------
    bit slave_normal = 1'b1;
    bit txn = 1'b0;
    int t = 0;

    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (slave_normal) begin
                if (!txn) begin
                    if (m_send) begin
                        txn = 1'b1;
                        t   = 0;
                    end
                end else begin
                    t++;
                    if (t == 2) m_busy = 1'b1;
                    else if (t == 22) begin
                        m_busy = 1'b0;
                        txn    = 1'b0;
                    end
                end
            end else begin
                txn = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0, send_cnt = 0, hi_len = 0, fall_cyc = 0, last_gap = -1;
    bit          fall_valid = 1'b0, prev_send = 1'b0, prev_busy = 1'b0;
    int          stable_bad = 0;
    logic [6:0]  cur_addr = '0;
    logic [7:0]  cur_data = '0;

    initial begin
        forever begin
            @(posedge CLOCK_50);
            #2;
            cyc++;
            if (m_send && !prev_send) begin
                send_cnt++;
                hi_len   = 1;
                cur_addr = m_addr;
                cur_data = m_data;
                if (fall_valid) last_gap = cyc - fall_cyc;
                fall_valid = 1'b0;
                if (exp_q.size() == 0) check("sb_extra_send", {m_addr, m_data}, 15'h0);
                else check("sb_send", {17'h0, m_addr, m_data}, {17'h0, exp_q.pop_front()});
            end else if (m_send) begin
                hi_len++;
            end
            if (!m_busy && prev_busy) begin
                fall_cyc   = cyc;
                fall_valid = 1'b1;
            end
            if (dbg_state == WAIT_DONE && (m_addr != cur_addr || m_data != cur_data))
                stable_bad++;
            prev_send = m_send;
            prev_busy = m_busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(2);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || err) && n < budget) begin
            cycles(1);
            n++;
        end
        check("run_end_bound", {31'h0, done | err}, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int n;

        cycles(3);
        reset = 1'b0;
        cycles(1);

        // Reset state
        check("rst_send", m_send, 0);
        check("rst_rw", m_rw, 0);
        check("rst_addr", m_addr, 0);
        check("rst_data", m_data, 0);
        check("rst_step", step, 0);
        check("rst_flags", {active, done, err}, 0);
        check("rst_state", dbg_state, IDLE);

        // Normal run: latency, data order, gap, stability
        push_run();
        send_cnt = 0;
        start = 1'b1;
        lat = 0;
        while (!m_send && lat < 10) begin
            cycles(1);
            lat++;
        end
        check("start_latency", lat, 3);
        check("rw_write", m_rw, 0);
        start = 1'b0;
        wait_end(2000);
        check("run1_done", done, 1);
        check("run1_active", active, 0);
        check("run1_err", err, 0);
        check("run1_step", step, 3);
        check("run1_sends", send_cnt, 4);
        check("run1_gap", last_gap, GAP_CYCLES + 2);
        check("wait_stable", stable_bad, 0);
        check("run1_sb_empty", exp_q.size(), 0);

        // Timeout: busy never rises
        slave_normal = 1'b0;
        m_busy = 1'b0;
        exp_q.push_back(exp_tab[0]);
        send_cnt = 0;
        pulse_start();
        wait_end(200);
        check("to_err", err, 1);
        check("to_done", done, 0);
        check("to_step", step, 0);
        check("to_send_low", m_send, 0);
        check("to_send_len", hi_len, ACK_TIMEOUT);
        cycles(30);
        check("to_no_more_sends", send_cnt, 1);
        check("to_err_sticky", err, 1);

        // busy already high when SEND is entered
        m_busy = 1'b1;
        push_run();
        send_cnt = 0;
        pulse_start();
        n = 0;
        while (!m_send && n < 20) begin
            cycles(1);
            n++;
        end
        check("early_send_seen", m_send, 1);
        cycles(1);
        check("early_send_drop", m_send, 0);
        check("early_send_len", hi_len, 1);
        check("early_state", dbg_state, WAIT_DONE);
        cycles(3);
        m_busy = 1'b0;
        slave_normal = 1'b1;
        wait_end(2000);
        check("early_done", done, 1);
        check("early_err", err, 0);
        check("early_sends", send_cnt, 4);

        // start toggling mid-run is ignored
        push_run();
        send_cnt = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            cycles(4);
            start = ~start;
        end
        start = 1'b0;
        wait_end(2000);
        check("tog_done", done, 1);
        check("tog_sends", send_cnt, 4);

        // second run from DONE clears done at run start
        push_run();
        send_cnt = 0;
        start = 1'b1;
        cycles(2);
        check("rerun_done_clr", done, 0);
        check("rerun_active", active, 1);
        start = 1'b0;
        wait_end(2000);
        check("rerun_done", done, 1);
        check("rerun_sends", send_cnt, 4);
        check("rerun_sb_empty", exp_q.size(), 0);

        // reset during WAIT_DONE of entry 2
        push_run();
        pulse_start();
        n = 0;
        while (!(step == 2 && dbg_state == WAIT_DONE) && n < 500) begin
            cycles(1);
            n++;
        end
        check("mid_reached", {step, dbg_state}, {4'd2, WAIT_DONE});
        reset = 1'b1;
        cycles(1);
        check("mid_rst_send", m_send, 0);
        check("mid_rst_addr", m_addr, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_step", step, 0);
        check("mid_rst_flags", {active, done, err}, 0);
        check("mid_rst_state", dbg_state, IDLE);
        reset = 1'b0;
        cycles(30);
        exp_q.delete();
        push_run();
        send_cnt = 0;
        pulse_start();
        wait_end(2000);
        check("mid_rerun_done", done, 1);
        check("mid_rerun_sends", send_cnt, 4);
        check("mid_rerun_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
